// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB slave register bank bridging PPC software to Simulink user logic.
// C_NUM_REGS live 32-bit control registers with byte-enable writes and
// per-register update strobes. An optional shadow bank lets software stage
// values and commit them all to the live bank on a single edge.
module opb_register_bank_ppc2simulink #(
  parameter logic [31:0] C_BASEADDR   = 32'h00000000,
  parameter logic [31:0] C_HIGHADDR   = 32'h000000FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter int          C_NUM_REGS   = 4,
  parameter int          C_SHADOW     = 0,
  parameter logic [31:0] C_RESET_VAL  = 32'h00000000
) (
  input  logic                      OPB_Clk,
  input  logic                      OPB_Rst,
  input  logic [0:31]               OPB_ABus,
  input  logic [0:3]                OPB_BE,
  input  logic [0:31]               OPB_DBus,
  input  logic                      OPB_RNW,
  input  logic                      OPB_select,
  input  logic                      OPB_seqAddr,
  output logic [0:31]               Sl_DBus,
  output logic                      Sl_xferAck,
  output logic                      Sl_errAck,
  output logic                      Sl_retry,
  output logic                      Sl_toutSup,
  output logic [32*C_NUM_REGS-1:0]  user_data_out,
  output logic [C_NUM_REGS-1:0]     user_wr_strobe
);

  // Window span and register count as 32-bit values for unsigned compares.
  localparam logic [31:0] LP_SPAN = C_HIGHADDR - C_BASEADDR;
  localparam logic [31:0] LP_NUM  = 32'(C_NUM_REGS);

  logic [31:0] r_live   [C_NUM_REGS];
  logic [31:0] r_shadow [C_NUM_REGS];
  logic [C_NUM_REGS-1:0] r_strobe;

  logic        r_ack;
  logic        r_busy;
  logic [31:0] r_rdata;
  logic [31:0] r_idx;
  logic        r_rnw;
  logic [0:3]  r_be;
  logic [31:0] r_wdata;

  logic [31:0] w_offset;
  logic [31:0] w_idx;
  logic        w_hit;
  logic        w_accept;
  logic [31:0] w_rdval;
  logic [31:0] w_mask;
  logic        w_commit;
  logic        w_unused;

  // Offset wraps to a huge value below the base, so one compare covers both bounds.
  assign w_offset = OPB_ABus - C_BASEADDR;
  assign w_hit    = OPB_select & (w_offset <= LP_SPAN);
  assign w_idx    = {2'b00, w_offset[31:2]};
  assign w_accept = w_hit & ~r_ack & ~r_busy;

  // BE[0] gates the most significant byte of the user-side word.
  assign w_mask   = {{8{r_be[0]}}, {8{r_be[1]}}, {8{r_be[2]}}, {8{r_be[3]}}};
  assign w_commit = (r_idx == LP_NUM) & r_wdata[0] & r_be[3];

  // Sequential-address hint carries no meaning for a single-beat slave.
  assign w_unused = OPB_seqAddr;

  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;
  assign Sl_xferAck = r_ack;
  assign Sl_DBus    = r_rdata;
  assign user_wr_strobe = r_strobe;

  genvar g;
  for (g = 0; g < C_NUM_REGS; g++) begin : g_out
    assign user_data_out[32*g +: 32] = r_live[g];
  end

  // Read mux: software sees the staging bank in shadow mode, live bank otherwise.
  always_comb begin
    w_rdval = '0;
    for (int k = 0; k < C_NUM_REGS; k++) begin
      if (w_idx == 32'(k)) begin
        w_rdval = (C_SHADOW != 0) ? r_shadow[k] : r_live[k];
      end
    end
  end

  // Bus handshake: capture the request on the sampling edge, ack the next cycle,
  // and stay busy until select drops so a held select is only acked once.
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
      r_rdata <= '0;
      r_idx   <= '0;
      r_rnw   <= 1'b1;
      r_be    <= '0;
      r_wdata <= '0;
    end else begin
      r_ack   <= w_accept;
      r_busy  <= OPB_select & (r_busy | r_ack);
      r_rdata <= (w_accept & OPB_RNW) ? w_rdval : 32'h0;
      if (w_accept) begin
        r_idx   <= w_idx;
        r_rnw   <= OPB_RNW;
        r_be    <= OPB_BE;
        r_wdata <= OPB_DBus;
      end
    end
  end

  // Register banks: writes land on the ack edge; strobes pulse the following cycle.
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      for (int k = 0; k < C_NUM_REGS; k++) begin
        r_live[k]   <= C_RESET_VAL;
        r_shadow[k] <= C_RESET_VAL;
      end
      r_strobe <= '0;
    end else begin
      r_strobe <= '0;
      if (r_ack & ~r_rnw) begin
        if (C_SHADOW == 0) begin
          for (int k = 0; k < C_NUM_REGS; k++) begin
            if (r_idx == 32'(k)) begin
              r_live[k]   <= (r_live[k] & ~w_mask) | (r_wdata & w_mask);
              r_strobe[k] <= 1'b1;
            end
          end
        end else begin
          for (int k = 0; k < C_NUM_REGS; k++) begin
            if (r_idx == 32'(k)) begin
              r_shadow[k] <= (r_shadow[k] & ~w_mask) | (r_wdata & w_mask);
            end
          end
          if (w_commit) begin
            for (int k = 0; k < C_NUM_REGS; k++) begin
              r_live[k] <= r_shadow[k];
            end
            r_strobe <= '1;
          end
        end
      end
    end
  end

endmodule

// File: doc/opb_register_bank_ppc2simulink.md
Name: opb_register_bank_ppc2simulink

Overview:
Parametrised successor to the single-word PPC-to-Simulink software register. It presents C_NUM_REGS 32-bit software-writable, readable control registers behind one OPB slave window, with byte-enable writes and per-register update strobes. An optional shadow/commit mode lets software stage several registers and apply them atomically. It sits between the PPC OPB bus and user (Simulink) logic, in a single clock domain.

Parameters:
C_BASEADDR, 32'h00000000, base address of the window (word aligned)
C_HIGHADDR, 32'h000000FF, top address of the window (inclusive)
C_OPB_AWIDTH, 32, OPB address width
C_OPB_DWIDTH, 32, OPB data width (only 32 supported)
C_NUM_REGS, 4, number of registers (1..32); window must hold C_NUM_REGS+1 words
C_SHADOW, 0, 1 = shadow/commit mode, 0 = direct write
C_RESET_VAL, 32'h00000000, reset value of every live and shadow register

Ports:
OPB_Clk  in  1  sole clock for bus and user side
OPB_Rst  in  1  synchronous active-high reset
OPB_ABus  in  [0:31]  address
OPB_BE  in  [0:3]  byte enables; BE[0] = DBus[0:7]
OPB_DBus  in  [0:31]  write data
OPB_RNW  in  1  1 = read, 0 = write
OPB_select  in  1  transfer request
OPB_seqAddr  in  1  ignored
Sl_DBus  out  [0:31]  read data, zero when not acking
Sl_xferAck  out  1  transfer acknowledge
Sl_errAck  out  1  tied 0
Sl_retry  out  1  tied 0
Sl_toutSup  out  1  tied 0
user_data_out  out  [32*C_NUM_REGS-1:0]  live registers; reg k in bits [32k+31:32k]
user_wr_strobe  out  [C_NUM_REGS-1:0]  one-cycle pulse per live-register update

Behaviour:
- Clock and reset: one clock, OPB_Clk; reset OPB_Rst is synchronous and active-high. Reset sets live and shadow registers to C_RESET_VAL, and Sl_xferAck, Sl_DBus and user_wr_strobe to 0. Reset mid-transfer drops the transfer with no ack. The master re-issues.
- Decode: hit = OPB_select & (C_BASEADDR <= ABus <= C_HIGHADDR). idx = (ABus - C_BASEADDR) >> 2.
- Handshake: cycle N samples the hit. In cycle N+1, Sl_xferAck = 1 for exactly one cycle. A busy flag blocks re-ack while select stays high in N+1. The next ack comes at the earliest in N+3, after select is re-sampled.
- Bit mapping: OPB bit i maps to user bit 31-i. BE[0] gates user bits [31:24], down to BE[3] gating [7:0].
- Direct mode (C_SHADOW=0) write: at the ack edge, live[idx] bytes with BE set take DBus; other bytes hold. user_wr_strobe[idx] pulses in the cycle after the ack, even when BE = 0000.
- Shadow mode (C_SHADOW=1) write, idx < C_NUM_REGS: only shadow[idx] updates and no strobe fires.
- Commit: a write to idx == C_NUM_REGS with user bit 0 = 1 and BE[3] = 1 copies every shadow register to live in a single edge. Every user_wr_strobe bit pulses the next cycle. A commit write with bit 0 = 0 has no effect.
- Read: during ack, Sl_DBus returns live[idx] in direct mode or shadow[idx] in shadow mode. In shadow mode, idx == C_NUM_REGS reads 0. Read side effects: none.
- Out of range: idx > C_NUM_REGS (or == C_NUM_REGS in direct mode) is still acked. Reads return 0; writes are ignored with no strobe.
- Outputs: user_data_out is registered, so live values appear the cycle after the ack edge, aligned with the strobe.
- Back-to-back: a write to reg k followed immediately by a read of reg k returns the new value.
- Latency: select to ack is 1 cycle; ack to user_data_out/strobe is 1 cycle.

Test Plan:
1. Reset with C_RESET_VAL = 32'hDEADBEEF, C_NUM_REGS = 4 -> all four words read DEADBEEF; strobes 0; xferAck 0 throughout reset.
2. Direct write 0x12345678, BE = 1111, to reg 2, then read reg 2 -> ack exactly 1 cycle after select; user_data_out[95:64] = 12345678 one cycle after ack; strobe = 4'b0100 for one cycle; read returns 12345678.
3. Byte-enable write of 0xAABBCCDD with BE = 0101 to reg 0, which holds 0x00000000 -> reg 0 = 0x00BB00DD.
4. Hold select for 4 cycles on one read -> exactly one xferAck pulse; Sl_DBus is 0 outside the ack cycle.
5. C_SHADOW = 1: write regs 0 and 1 with 0x1 and 0x2 -> user_data_out unchanged and no strobes. Then write 1 to the commit word -> both live registers update on the same edge; strobe = 4'b1111 for one cycle.
6. Write to idx 7 (out of range) -> acked; no register changes; read of idx 7 returns 0. Assert OPB_Rst in the select cycle -> no ack and no write.
